game_step_ctrl: RTL and testbench

GAME_STEP_CTRL -- requirements
Module: game_step_ctrl

---
 rtl/game_step_ctrl.sv | 122 ++++++++++++
 tb/tb_game_step_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/game_step_ctrl.sv
// Game step controller: turns the asynchronous divided game tick into single-cycle
// step pulses while running, and handles the speed and start/pause/restart buttons.
module game_step_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_game,
    input  logic             btn_up,
    input  logic             btn_down,
    input  logic             btn_start,
    input  logic             game_over,
    output logic [1:0]       clk_rate,
    output logic             step,
    output logic [CNT_W-1:0] step_count,
    output logic [1:0]       state
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    logic             s1_r, s2_r, s3_r;
    logic             tick_rise_s;
    logic             up_prev_r, down_prev_r, start_prev_r;
    logic             up_edge_s, down_edge_s, start_edge_s;
    logic [1:0]       state_r, state_next_s;
    logic [1:0]       rate_r, rate_next_s;
    logic             step_r, step_next_s;
    logic [CNT_W-1:0] count_r, count_next_s;

    assign tick_rise_s  = s2_r & ~s3_r;
    assign up_edge_s    = btn_up & ~up_prev_r;
    assign down_edge_s  = btn_down & ~down_prev_r;
    assign start_edge_s = btn_start & ~start_prev_r;

    // Tick synchronizer and button history; these run in every FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r         <= 1'b0;
            s2_r         <= 1'b0;
            s3_r         <= 1'b0;
            up_prev_r    <= 1'b0;
            down_prev_r  <= 1'b0;
            start_prev_r <= 1'b0;
        end else begin
            s1_r         <= clk_game;
            s2_r         <= s1_r;
            s3_r         <= s2_r;
            up_prev_r    <= btn_up;
            down_prev_r  <= btn_down;
            start_prev_r <= btn_start;
        end
    end

    // Rate select: saturating up/down, simultaneous edges cancel.
    always_comb begin
        rate_next_s = rate_r;
        if (up_edge_s && !down_edge_s) begin
            rate_next_s = (rate_r == 2'd3) ? 2'd3 : rate_r + 2'd1;
        end else if (down_edge_s && !up_edge_s) begin
            rate_next_s = (rate_r == 2'd0) ? 2'd0 : rate_r - 2'd1;
        end else begin
            rate_next_s = rate_r;
        end
    end

    // FSM state register plus registered step, count and rate outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            rate_r  <= 2'd0;
            step_r  <= 1'b0;
            count_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            rate_r  <= rate_next_s;
            step_r  <= step_next_s;
            count_r <= count_next_s;
        end
    end

    // Next-state logic; game_over wins over a same-cycle start edge in RUN.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  state_next_s = start_edge_s ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                if (game_over) begin
                    state_next_s = ST_OVER;
                end else if (start_edge_s) begin
                    state_next_s = ST_PAUSE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_PAUSE: state_next_s = start_edge_s ? ST_RUN : ST_PAUSE;
            ST_OVER:  state_next_s = start_edge_s ? ST_IDLE : ST_OVER;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Step gating uses the pre-transition state, so a tick landing on the
    // PAUSE->RUN edge is dropped rather than replayed.
    always_comb begin
        step_next_s  = tick_rise_s & (state_r == ST_RUN);
        count_next_s = count_r;
        if ((state_r == ST_IDLE) && start_edge_s) begin
            count_next_s = {CNT_W{1'b0}};
        end else if (step_next_s) begin
            count_next_s = count_r + CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    assign clk_rate   = rate_r;
    assign step       = step_r;
    assign step_count = count_r;
    assign state      = state_r;

endmodule

// File: tb/tb_game_step_ctrl.sv
// Bench for game_step_ctrl: directed scenarios checked against an event-level
// reference model on every cycle, plus literal expectations at key points.
module tb_game_step_ctrl;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         clk_game = 1'b0;
    logic         btn_up = 1'b0;
    logic         btn_down = 1'b0;
    logic         btn_start = 1'b0;
    logic         game_over = 1'b0;
    logic [1:0]   clk_rate;
    logic         step;
    logic [W-1:0] step_count;
    logic [1:0]   state;

    int vectors = 0;
    int miscompares = 0;
    int step_seen = 0;

    game_step_ctrl #(.CNT_W(W)) dut (
        .clk(clk), .rst(rst), .clk_game(clk_game), .btn_up(btn_up),
        .btn_down(btn_down), .btn_start(btn_start), .game_over(game_over),
        .clk_rate(clk_rate), .step(step), .step_count(step_count), .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: game-tick rises schedule a step two edges later,
    // taken only if the game is running at that edge.
    int m_state = 0, m_rate = 0, m_count = 0, m_step = 0;
    bit m_valid = 0;
    bit last_g = 0, last_up = 0, last_dn = 0, last_st = 0;
    longint cyc = 0;
    longint due[$];

    always @(posedge clk) begin
        bit g_rise, up_e, dn_e, st_e;
        if (rst) begin
            m_state = 0; m_rate = 0; m_count = 0; m_step = 0;
            last_g = 0; last_up = 0; last_dn = 0; last_st = 0;
            due.delete();
            m_valid = 1;
        end else begin
            cyc++;
            g_rise = clk_game && !last_g;
            up_e = btn_up && !last_up;
            dn_e = btn_down && !last_dn;
            st_e = btn_start && !last_st;
            last_g = clk_game; last_up = btn_up; last_dn = btn_down; last_st = btn_start;
            m_step = 0;
            while (due.size() > 0 && due[0] <= cyc) begin
                if (due[0] == cyc && m_state == 1) m_step = 1;
                void'(due.pop_front());
            end
            if (g_rise) due.push_back(cyc + 2);
            if (m_step) m_count = (m_count + 1) % (1 << W);
            if (up_e && !dn_e && m_rate < 3) m_rate++;
            else if (dn_e && !up_e && m_rate > 0) m_rate--;
            case (m_state)
                0: if (st_e) begin m_state = 1; m_count = 0; end
                1: if (game_over) m_state = 3; else if (st_e) m_state = 2;
                2: if (st_e) m_state = 1;
                default: if (st_e) m_state = 0;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            vectors++;
            if (state !== 2'(m_state) || clk_rate !== 2'(m_rate) ||
                step !== 1'(m_step) || step_count !== W'(m_count)) begin
                miscompares++;
                $display("FAIL model t=%0t: got state=%0d rate=%0d step=%0d count=%0d, want state=%0d rate=%0d step=%0d count=%0d",
                         $time, state, clk_rate, step, step_count, m_state, m_rate, m_step, m_count);
            end
            if (step === 1'b1) step_seen++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    task automatic game_period(input int hi, input int lo);
        clk_game = 1'b1; tick(hi);
        clk_game = 1'b0; tick(lo);
    endtask

    task automatic pulse_start();
        btn_start = 1'b1; tick(1);
        btn_start = 1'b0; tick(1);
    endtask

    initial begin
        int base;
        int exp_up[4] = '{1, 2, 3, 3};
        int exp_dn[3] = '{2, 1, 0};

        rst = 1'b1; tick(2); rst = 1'b0;
        check("reset_state", state, 0);
        check("reset_rate", clk_rate, 0);
        check("reset_count", step_count, 0);
        check("reset_step", step, 0);

        pulse_start();
        check("start_run", state, 1);
        base = step_seen;
        for (int i = 0; i < 5; i++) game_period(8, 8);
        check("run_steps", step_seen - base, 5);
        check("run_count", step_count, 5);
        check("run_state", state, 1);

        for (int i = 0; i < 4; i++) begin
            btn_up = 1'b1; tick(1); btn_up = 1'b0; tick(1);
            check("rate_up", clk_rate, exp_up[i]);
        end
        for (int i = 0; i < 3; i++) begin
            btn_down = 1'b1; tick(1); btn_down = 1'b0; tick(1);
            check("rate_down", clk_rate, exp_dn[i]);
        end
        btn_up = 1'b1; btn_down = 1'b1; tick(1);
        btn_up = 1'b0; btn_down = 1'b0; tick(1);
        check("rate_both", clk_rate, 0);

        pulse_start();
        check("pause_state", state, 2);
        base = step_seen;
        for (int i = 0; i < 3; i++) game_period(8, 8);
        check("pause_no_step", step_seen - base, 0);
        check("pause_count", step_count, 5);
        pulse_start();
        check("resume_state", state, 1);
        base = step_seen;
        game_period(8, 8);
        check("resume_one_step", step_seen - base, 1);
        check("resume_count", step_count, 6);

        game_over = 1'b1; btn_start = 1'b1; tick(1);
        game_over = 1'b0; btn_start = 1'b0; tick(1);
        check("over_priority", state, 3);
        pulse_start();
        check("over_to_idle", state, 0);
        pulse_start();
        check("restart_run", state, 1);
        check("restart_count", step_count, 0);

        for (int i = 1; i <= 17; i++) begin
            game_period(3, 3);
            if (i == 15) check("wrap_15", step_count, 15);
            if (i == 16) check("wrap_0", step_count, 0);
        end
        check("wrap_end", step_count, 1);

        base = step_seen;
        clk_game = 1'b1; tick(2);
        rst = 1'b1; btn_up = 1'b1; tick(1);
        check("rst_step", step, 0);
        check("rst_state", state, 0);
        check("rst_count", step_count, 0);
        check("rst_rate", clk_rate, 0);
        rst = 1'b0; tick(1);
        check("held_btn_once", clk_rate, 1);
        tick(2);
        check("held_btn_hold", clk_rate, 1);
        btn_up = 1'b0; clk_game = 1'b0; tick(4);
        check("rst_no_step", step_seen - base, 0);
        check("rst_idle", state, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
